// File: rtl/cycle_mode_ctrl.sv
// Button front-end and mode/setup sequencer for the cycle computer.
// Debounces Trip/Mode, classifies short/long/chord events, drives the wheel-size block.
module cycle_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 2048,
  parameter int unsigned SETUP_TIMEOUT   = 1048576
) (
  input  logic       clock,
  input  logic       nRst,
  input  logic       nTripBtn,
  input  logic       nModeBtn,
  input  logic       ws_ready,
  output logic       nTrip,
  output logic       nMode,
  output logic       ws_en,
  output logic [1:0] mode,
  output logic       trip_clear,
  output logic       in_setup
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam int unsigned TW = $clog2(SETUP_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, CLEAR, SETUP} state_t;

  // index 0 = Trip, index 1 = Mode
  logic [1:0]    sync1, sync2, db, db_q, used;
  logic [DW-1:0] db_cnt [2];
  logic [LW-1:0] hold   [2];
  logic          chord_act, ws_q;
  logic [TW-1:0] idle;
  state_t        state;

  logic          chord_c;
  logic [1:0]    long_c, short_c;
  logic          ws_rise_c;

  // 2-flop synchroniser and per-button debounce counter
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
      db    <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {nModeBtn, nTripBtn};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db[i]     <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Event classification; a chord outranks a long event in the same cycle
  always_comb begin
    chord_c   = 1'b0;
    long_c    = 2'b00;
    short_c   = 2'b00;
    ws_rise_c = ws_ready & ~ws_q;
    chord_c   = ~db[0] & ~db[1] & ~chord_act;
    for (int i = 0; i < 2; i++) begin
      long_c[i]  = ~db[i] & (hold[i] == LW'(LONG_CYCLES - 1)) & ~used[i] & ~chord_act & ~chord_c;
      short_c[i] = db[i] & ~db_q[i] & ~used[i] & ~chord_act;
    end
  end

  // Per-press bookkeeping: hold time, whether the press was consumed, chord lockout
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      db_q      <= 2'b11;
      used      <= 2'b00;
      chord_act <= 1'b0;
      ws_q      <= 1'b0;
      for (int i = 0; i < 2; i++) hold[i] <= '0;
    end else begin
      db_q      <= db;
      ws_q      <= ws_ready;
      chord_act <= chord_c | (chord_act & ~(db[0] & db[1]));
      for (int i = 0; i < 2; i++) begin
        used[i] <= db[i] ? 1'b0 : (used[i] | long_c[i] | chord_c);
        if (db[i])
          hold[i] <= '0;
        else if (hold[i] != LW'(LONG_CYCLES - 1))
          hold[i] <= hold[i] + LW'(1);
      end
    end
  end

  // Mode/setup sequencer with registered outputs
  always_ff @(posedge clock or negedge nRst) begin
    if (!nRst) begin
      state      <= RUN;
      nTrip      <= 1'b1;
      nMode      <= 1'b1;
      ws_en      <= 1'b0;
      mode       <= 2'd0;
      trip_clear <= 1'b0;
      in_setup   <= 1'b0;
      idle       <= '0;
    end else begin
      nTrip      <= 1'b1;
      nMode      <= 1'b1;
      trip_clear <= 1'b0;
      case (state)
        RUN: begin
          if (chord_c) begin
            nTrip <= 1'b0;
            nMode <= 1'b0;
          end else if (long_c[0]) begin
            trip_clear <= 1'b1;
          end else if (short_c[1]) begin
            mode <= mode + 2'd1;
          end else if (long_c[1]) begin
            state    <= ws_ready ? CLEAR : SETUP;
            ws_en    <= 1'b1;
            in_setup <= 1'b1;
            idle     <= '0;
          end
        end
        CLEAR: begin
          nTrip <= 1'b0;
          nMode <= 1'b0;
          state <= SETUP;
          idle  <= '0;
        end
        SETUP: begin
          if (ws_rise_c) begin
            state    <= RUN;
            ws_en    <= 1'b0;
            in_setup <= 1'b0;
          end else if (chord_c || idle == TW'(SETUP_TIMEOUT - 1)) begin
            nTrip    <= 1'b0;
            nMode    <= 1'b0;
            state    <= RUN;
            ws_en    <= 1'b0;
            in_setup <= 1'b0;
          end else if (short_c[0]) begin
            nTrip <= 1'b0;
            idle  <= '0;
          end else if (short_c[1]) begin
            nMode <= 1'b0;
            idle  <= '0;
          end else if (|long_c) begin
            idle <= '0;
          end else begin
            idle <= idle + TW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
